// File: rtl/shift_rows_pipe_pkg.sv
// Shared AES ShiftRows definitions: byte geometry, Rijndael row offsets and
// a width-generic permutation reused by the datapath and key-expansion checkers.
package shift_rows_pipe_pkg;

   localparam int BYTE_W = 8;
   localparam int ROWS   = 4;
   localparam int MAX_NB = 8;
   localparam int MAX_W  = ROWS * BYTE_W * MAX_NB;

   typedef logic [BYTE_W-1:0] byte_t;

   // Rijndael offsets: {0,1,2,3} for Nb=4/6, {0,1,3,4} for Nb=8.
   function automatic int sr_offset(input int nb, input int row);
      if (nb == 8 && row >= 2) return row + 1;
      return row;
   endfunction

   function automatic int sr_src_col(input int nb, input int row, input int col, input logic inv);
      int s;
      s = sr_offset(nb, row);
      if (inv) return (col - s + nb) % nb;
      return (col + s) % nb;
   endfunction

   function automatic logic [0:MAX_W-1] shift_rows_f(input logic [0:MAX_W-1] state,
                                                     input int nb, input logic inv);
      logic [0:MAX_W-1] res;
      res = '0;
      for (int c = 0; c < MAX_NB; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            if (c < nb)
               res[BYTE_W*(ROWS*c+r) +: BYTE_W] =
                  state[BYTE_W*(ROWS*sr_src_col(nb, r, c, inv)+r) +: BYTE_W];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// Valid/ready stream bundle around the ShiftRows stage: upstream beat with
// direction flag and tag, downstream shifted beat with tag.
interface shift_rows_pipe_if #(
   parameter int NB    = 4,
   parameter int TAG_W = 4
);
   logic               in_valid;
   logic               in_ready;
   logic               in_inv;
   logic [TAG_W-1:0]   in_tag;
   logic [0:32*NB-1]   state_in;
   logic               out_valid;
   logic               out_ready;
   logic [TAG_W-1:0]   out_tag;
   logic [0:32*NB-1]   state_out;

   modport master (
      output in_valid, in_inv, in_tag, state_in, out_ready,
      input  in_ready, out_valid, out_tag, state_out
   );

   modport slave (
      input  in_valid, in_inv, in_tag, state_in, out_ready,
      output in_ready, out_valid, out_tag, state_out
   );
endinterface

// File: rtl/shift_rows_pipe_slice.sv
// Single-entry elastic register slice; a full slice can be drained and
// refilled in the same cycle so a stream of slices sustains one beat per cycle.
module shift_rows_pipe_slice #(
   parameter int W = 132
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_data  <= in_data;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/shift_rows_pipe.sv
// Pipelined Rijndael ShiftRows / InvShiftRows for Nb = 4/6/8: the byte
// permutation is combinational ahead of a chain of STAGES elastic slices.
module shift_rows_pipe
   import shift_rows_pipe_pkg::*;
#(
   parameter int NB     = 4,
   parameter int STAGES = 1,
   parameter int TAG_W  = 4
) (
   input logic              clk,
   input logic              rst_n,
   shift_rows_pipe_if.slave bus
);

   localparam int SW = ROWS * BYTE_W * NB;
   localparam int W  = SW + TAG_W;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("shift_rows_pipe: STAGES must be 1..4");
   end

   logic [0:SW-1] fwd_p0;
   logic [0:SW-1] inv_p0;
   logic [0:SW-1] perm_p0;

   // p0: both directions are fixed wirings; the beat's flag selects one.
   always_comb begin
      fwd_p0 = '0;
      inv_p0 = '0;
      for (int c = 0; c < NB; c++) begin
         for (int r = 0; r < ROWS; r++) begin
            fwd_p0[BYTE_W*(ROWS*c+r) +: BYTE_W] =
               bus.state_in[BYTE_W*(ROWS*sr_src_col(NB, r, c, 1'b0)+r) +: BYTE_W];
            inv_p0[BYTE_W*(ROWS*c+r) +: BYTE_W] =
               bus.state_in[BYTE_W*(ROWS*sr_src_col(NB, r, c, 1'b1)+r) +: BYTE_W];
         end
      end
   end

   assign perm_p0 = bus.in_inv ? inv_p0 : fwd_p0;

   logic         vld_p [0:STAGES];
   logic         rdy_p [0:STAGES];
   logic [W-1:0] dat_p [0:STAGES];

   assign vld_p[0]      = bus.in_valid;
   assign dat_p[0]      = {perm_p0, bus.in_tag};
   assign rdy_p[STAGES] = bus.out_ready;

   // p1..pSTAGES: elastic slice chain carrying permuted state plus tag.
   for (genvar k = 0; k < STAGES; k++) begin : g_slice
      shift_rows_pipe_slice #(.W(W)) u_slice (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (vld_p[k]),
         .in_ready  (rdy_p[k]),
         .in_data   (dat_p[k]),
         .out_valid (vld_p[k+1]),
         .out_ready (rdy_p[k+1]),
         .out_data  (dat_p[k+1])
      );
   end

   // Upstream is refused during reset so nothing is believed accepted.
   assign bus.in_ready  = rdy_p[0] && rst_n;
   assign bus.out_valid = vld_p[STAGES];
   assign bus.state_out = dat_p[STAGES][W-1 -: SW];
   assign bus.out_tag   = dat_p[STAGES][TAG_W-1:0];

endmodule

// File: tb/tb_shift_rows_pipe.sv
// Bench for shift_rows_pipe: known AES vectors, Nb=8 offsets, elastic
// behaviour under random handshakes, backpressure and mid-flight reset.
module tb_shift_rows_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   shift_rows_pipe_if #(.NB(4), .TAG_W(4)) if4 ();
   shift_rows_pipe_if #(.NB(8), .TAG_W(4)) if8 ();
   shift_rows_pipe_if #(.NB(4), .TAG_W(4)) if3 ();

   shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(if4));
   shift_rows_pipe #(.NB(8), .STAGES(1), .TAG_W(4)) u_n8 (.clk(clk), .rst_n(rst_n), .bus(if8));
   shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_s3 (.clk(clk), .rst_n(rst_n), .bus(if3));

   localparam logic [0:127] K_A = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [0:127] K_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

   // Reference: each row is a queue of bytes rotated by its Rijndael offset.
   function automatic logic [0:255] ref_shift(input logic [0:255] st, input int nb, input bit inv);
      logic [0:255] res;
      logic [7:0]   row[$];
      int           sh8[4];
      int           s;
      sh8 = '{0, 1, 3, 4};
      res = '0;
      for (int r = 0; r < 4; r++) begin
         s = (nb == 8) ? sh8[r] : r;
         row.delete();
         for (int c = 0; c < nb; c++) row.push_back(st[8*(4*c+r) +: 8]);
         repeat (s) begin
            if (!inv) row.push_back(row.pop_front());
            else      row.push_front(row.pop_back());
         end
         for (int c = 0; c < nb; c++) res[8*(4*c+r) +: 8] = row[c];
      end
      return res;
   endfunction

   function automatic logic [0:127] ref4(input logic [0:127] st, input bit inv);
      logic [0:255] t;
      t = ref_shift({st, 128'h0}, 4, inv);
      return t[0:127];
   endfunction

   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      if4.in_valid = 0; if4.in_inv = 0; if4.in_tag = 0; if4.state_in = '0; if4.out_ready = 1;
      if8.in_valid = 0; if8.in_inv = 0; if8.in_tag = 0; if8.state_in = '0; if8.out_ready = 1;
      if3.in_valid = 0; if3.in_inv = 0; if3.in_tag = 0; if3.state_in = '0; if3.out_ready = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      idle_all();
      if3.in_valid = 1;
      if3.state_in = rnd128();
      repeat (3) tick();
      @(negedge clk);
      total++; if (if4.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b want=0", if4.in_ready); end
      total++; if (if3.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready_s3 got=%0b want=0", if3.in_ready); end
      total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", if3.out_valid); end
      total++; if (if3.state_out !== 128'h0) begin bad++; $display("FAIL reset_state got=%h want=0", if3.state_out); end
      total++; if (if8.out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag got=%h want=0", if8.out_tag); end
      tick();
      rst_n = 1;
      if3.in_valid = 0;
      @(negedge clk);
      total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b want=1", if4.in_ready); end
      total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready_s3 got=%0b want=1", if3.in_ready); end
   endtask

   task automatic test_known4(input logic [0:127] din, input logic [0:127] dout, input bit inv, input logic [3:0] tag);
      tick();
      if4.in_valid = 1; if4.in_inv = inv; if4.in_tag = tag; if4.state_in = din; if4.out_ready = 1;
      @(negedge clk);
      total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL known_accept got=%0b want=1", if4.in_ready); end
      tick();
      if4.in_valid = 0; if4.state_in = rnd128(); if4.in_tag = ~tag;
      @(negedge clk);
      total++; if (if4.out_valid !== 1'b1) begin bad++; $display("FAIL known_valid inv=%0b got=%0b want=1", inv, if4.out_valid); end
      total++; if (if4.state_out !== dout) begin bad++; $display("FAIL known_state inv=%0b got=%h want=%h", inv, if4.state_out, dout); end
      total++; if (if4.state_out !== ref4(din, inv)) begin bad++; $display("FAIL known_model inv=%0b got=%h want=%h", inv, if4.state_out, ref4(din, inv)); end
      total++; if (if4.out_tag !== tag) begin bad++; $display("FAIL known_tag got=%h want=%h", if4.out_tag, tag); end
      tick();
      @(negedge clk);
      total++; if (if4.out_valid !== 1'b0) begin bad++; $display("FAIL known_no_dup got=%0b want=0", if4.out_valid); end
   endtask

   task automatic test_nb8();
      logic [0:255] din, exp;
      for (int k = 0; k < 32; k++) din[8*k +: 8] = k[7:0];
      for (int t = 0; t < 7; t++) begin
         bit inv;
         inv = (t % 2 == 1);
         if (t > 0) din = {rnd128(), rnd128()};
         exp = ref_shift(din, 8, inv);
         tick();
         if8.in_valid = 1; if8.in_inv = inv; if8.in_tag = t[3:0]; if8.state_in = din;
         tick();
         if8.in_valid = 0; if8.state_in = '0;
         @(negedge clk);
         total++; if (if8.out_valid !== 1'b1) begin bad++; $display("FAIL nb8_valid t=%0d got=%0b want=1", t, if8.out_valid); end
         total++; if (if8.state_out !== exp) begin bad++; $display("FAIL nb8_state t=%0d got=%h want=%h", t, if8.state_out, exp); end
         total++; if (if8.out_tag !== t[3:0]) begin bad++; $display("FAIL nb8_tag t=%0d got=%h want=%h", t, if8.out_tag, t[3:0]); end
         if (t == 0) begin
            total++; if (if8.state_out[16:23] !== 8'h0e) begin bad++; $display("FAIL nb8_byte2 got=%h want=0e", if8.state_out[16:23]); end
            total++; if (if8.state_out[24:31] !== 8'h13) begin bad++; $display("FAIL nb8_byte3 got=%h want=13", if8.state_out[24:31]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [0:127] exp_st [10];
      logic [3:0]   exp_tag [10];
      if4.out_ready = 1;
      for (int i = 0; i <= 10; i++) begin
         tick();
         if (i < 10) begin
            logic [0:127] d;
            d = rnd128();
            exp_st[i] = ref4(d, i[0]);
            exp_tag[i] = 4'($urandom);
            if4.in_valid = 1; if4.in_inv = i[0]; if4.in_tag = exp_tag[i]; if4.state_in = d;
         end else begin
            if4.in_valid = 0;
         end
         @(negedge clk);
         if (i < 10) begin
            total++; if (if4.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%0b want=1", i, if4.in_ready); end
         end
         if (i > 0) begin
            total++;
            if (if4.out_valid !== 1'b1 || if4.state_out !== exp_st[i-1] || if4.out_tag !== exp_tag[i-1]) begin
               bad++; $display("FAIL b2b_beat i=%0d got=%0b/%h/%h want=1/%h/%h", i-1, if4.out_valid, if4.state_out, if4.out_tag, exp_st[i-1], exp_tag[i-1]);
            end
         end
      end
   endtask

   task automatic test_latency();
      logic [0:127] d;
      int lat;
      d = rnd128();
      lat = 0;
      if3.out_ready = 1;
      tick();
      if3.in_valid = 1; if3.in_inv = 1; if3.in_tag = 4'h9; if3.state_in = d;
      @(negedge clk);
      total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL lat_accept got=%0b want=1", if3.in_ready); end
      tick();
      if3.in_valid = 0;
      for (int n = 1; n <= 10; n++) begin
         if (n > 1) tick();
         @(negedge clk);
         if (if3.out_valid === 1'b1) begin lat = n; break; end
      end
      total++; if (lat != 3) begin bad++; $display("FAIL latency got=%0d want=3", lat); end
      total++; if (if3.state_out !== ref4(d, 1'b1)) begin bad++; $display("FAIL lat_state got=%h want=%h", if3.state_out, ref4(d, 1'b1)); end
      tick();
      @(negedge clk);
      total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL lat_no_dup got=%0b want=0", if3.out_valid); end
   endtask

   task automatic test_random();
      logic [0:127] exp_st[$];
      logic [3:0]   exp_tag[$];
      logic [0:127] cur_st;
      logic [3:0]   cur_tag;
      int sent, got, cyc, errs;
      sent = 0; got = 0; cyc = 0; errs = 0;
      cur_st = rnd128(); cur_tag = 4'($urandom);
      while (got < 100 && cyc < 3000) begin
         tick();
         cyc++;
         if3.in_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
         if3.in_inv = sent[0];
         if3.in_tag = if3.in_valid ? cur_tag : 4'($urandom);
         if3.state_in = if3.in_valid ? cur_st : rnd128();
         if3.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (if3.out_valid && if3.out_ready) begin
            total++;
            if (exp_st.size() == 0) begin
               bad++; errs++; $display("FAIL rand_extra got=%h want=none", if3.state_out);
            end else begin
               if (if3.state_out !== exp_st[0] || if3.out_tag !== exp_tag[0]) begin
                  bad++; errs++;
                  if (errs < 5) $display("FAIL rand_beat n=%0d got=%h/%h want=%h/%h", got, if3.state_out, if3.out_tag, exp_st[0], exp_tag[0]);
               end
               void'(exp_st.pop_front());
               void'(exp_tag.pop_front());
            end
            got++;
         end
         if (if3.in_valid && if3.in_ready) begin
            exp_st.push_back(ref4(cur_st, sent[0]));
            exp_tag.push_back(cur_tag);
            sent++;
            cur_st = rnd128(); cur_tag = 4'($urandom);
         end
      end
      total++; if (got != 100 || sent != 100) begin bad++; $display("FAIL rand_count got=%0d sent=%0d want=100", got, sent); end
      if3.in_valid = 0; if3.out_ready = 1;
      repeat (5) begin
         tick();
         @(negedge clk);
         total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL rand_drain got=%0b want=0", if3.out_valid); end
      end
   endtask

   task automatic test_hold();
      logic [0:127] exp_st[$];
      logic [3:0]   exp_tag[$];
      logic [0:127] cur_st, held_st;
      logic [3:0]   cur_tag, held_tag;
      bit seen;
      int acc, got;
      seen = 0; acc = 0; got = 0;
      held_st = '0; held_tag = '0;
      cur_st = rnd128(); cur_tag = 4'($urandom);
      if3.out_ready = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if3.in_valid = 1; if3.in_inv = acc[0]; if3.in_tag = cur_tag; if3.state_in = cur_st;
         @(negedge clk);
         if (if3.out_valid) begin
            if (!seen) begin
               seen = 1; held_st = if3.state_out; held_tag = if3.out_tag;
            end else begin
               total++;
               if (if3.state_out !== held_st || if3.out_tag !== held_tag) begin
                  bad++; $display("FAIL hold_stable i=%0d got=%h/%h want=%h/%h", i, if3.state_out, if3.out_tag, held_st, held_tag);
               end
            end
         end
         if (if3.in_valid && if3.in_ready) begin
            exp_st.push_back(ref4(cur_st, acc[0]));
            exp_tag.push_back(cur_tag);
            acc++;
            cur_st = rnd128(); cur_tag = 4'($urandom);
         end
      end
      total++; if (acc != 3) begin bad++; $display("FAIL hold_accepted got=%0d want=3", acc); end
      total++; if (if3.in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready got=%0b want=0", if3.in_ready); end
      total++; if (seen && (exp_st.size() == 0 || held_st !== exp_st[0])) begin bad++; $display("FAIL hold_head got=%h", held_st); end
      tick();
      if3.in_valid = 0; if3.out_ready = 1;
      for (int i = 0; i < 10 && got < acc; i++) begin
         @(negedge clk);
         if (if3.out_valid) begin
            total++;
            if (exp_st.size() == 0 || if3.state_out !== exp_st[0] || if3.out_tag !== exp_tag[0]) begin
               bad++; $display("FAIL hold_drain n=%0d got=%h/%h", got, if3.state_out, if3.out_tag);
            end
            if (exp_st.size() != 0) begin void'(exp_st.pop_front()); void'(exp_tag.pop_front()); end
            got++;
         end
         tick();
      end
      total++; if (got != 3) begin bad++; $display("FAIL hold_drain_count got=%0d want=3", got); end
   endtask

   task automatic test_reset_flight();
      if3.out_ready = 1;
      for (int b = 0; b < 2; b++) begin
         tick();
         if3.in_valid = 1; if3.in_inv = b[0]; if3.in_tag = 4'(b + 1); if3.state_in = rnd128();
         @(negedge clk);
         total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL flight_accept b=%0d got=%0b want=1", b, if3.in_ready); end
      end
      tick();
      rst_n = 0;
      if3.state_in = rnd128();
      @(negedge clk);
      total++; if (if3.in_ready !== 1'b0) begin bad++; $display("FAIL flight_rst_ready got=%0b want=0", if3.in_ready); end
      repeat (3) begin
         tick();
         @(negedge clk);
         total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL flight_rst_valid got=%0b want=0", if3.out_valid); end
      end
      tick();
      rst_n = 1;
      if3.in_valid = 0;
      @(negedge clk);
      total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL flight_release_ready got=%0b want=1", if3.in_ready); end
      repeat (6) begin
         total++; if (if3.out_valid !== 1'b0) begin bad++; $display("FAIL flight_stale got=%0b want=0", if3.out_valid); end
         tick();
         @(negedge clk);
      end
   endtask

   initial begin
      idle_all();
      test_reset();
      test_known4(K_A, K_B, 1'b0, 4'h5);
      test_known4(K_B, K_A, 1'b1, 4'ha);
      test_nb8();
      test_back_to_back();
      test_latency();
      test_random();
      test_hold();
      test_reset_flight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
